// File: rtl/sa_cache_ctrl_if.sv
// sa_cache_ctrl_if: command, response, backing-memory and statistics signals of the cache controller
interface sa_cache_ctrl_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_hit;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_req_we;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [DATA_W-1:0] mem_req_wdata;
    logic              mem_rsp_valid;
    logic [DATA_W-1:0] mem_rsp_rdata;
    logic [CNT_W-1:0]  hit_cnt;
    logic [CNT_W-1:0]  miss_cnt;

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_hit, mem_req_valid, mem_req_we, mem_req_addr,
               mem_req_wdata, hit_cnt, miss_cnt
    );

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_wdata, mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_hit, mem_req_valid, mem_req_we, mem_req_addr,
               mem_req_wdata, hit_cnt, miss_cnt
    );
endinterface

// File: rtl/sa_cache_ctrl.sv
// sa_cache_ctrl: 2-way set-associative write-through, no-write-allocate cache controller with LRU replacement
module sa_cache_ctrl #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 32,
    parameter int SET_BITS = 4,
    parameter int CNT_W    = 16
) (
    input logic             clk,
    input logic             rst_n,
    sa_cache_ctrl_if.slave  bus
);
    localparam int TAG_W = ADDR_W - SET_BITS;
    localparam int NSETS = 1 << SET_BITS;
    localparam logic [1:0] OP_NOP = 2'd0, OP_RD = 2'd1, OP_WR = 2'd2, OP_FL = 2'd3;

    typedef enum logic [2:0] {IDLE, LOOKUP, MEM_REQ, MEM_WAIT, FLUSH, RESP} state_t;

    state_t            r_state;
    logic [1:0]        r_op;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_hit;
    logic [SET_BITS:0] r_fcnt;
    logic [1:0]        r_valid [NSETS];
    logic [NSETS-1:0]  r_lru;
    logic [TAG_W-1:0]  r_tag  [2][NSETS];
    logic [DATA_W-1:0] r_data [2][NSETS];
    logic              r_rsp_valid, r_rsp_hit;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_req_valid, r_req_we;
    logic [ADDR_W-1:0] r_req_addr;
    logic [DATA_W-1:0] r_req_wdata;
    logic [CNT_W-1:0]  r_hit_cnt, r_miss_cnt;

    logic [SET_BITS-1:0] w_set;
    logic [TAG_W-1:0]    w_tag;
    logic [1:0]          w_hits;
    logic                w_hit, w_way, w_victim;

    assign w_set    = r_addr[SET_BITS-1:0];
    assign w_tag    = r_addr[ADDR_W-1:SET_BITS];
    assign w_hits[0] = r_valid[w_set][0] && (r_tag[0][w_set] == w_tag);
    assign w_hits[1] = r_valid[w_set][1] && (r_tag[1][w_set] == w_tag);
    assign w_hit    = |w_hits;
    assign w_way    = w_hits[1];
    // r_lru[set] names the least recently used way
    assign w_victim = !r_valid[w_set][0] ? 1'b0 : !r_valid[w_set][1] ? 1'b1 : r_lru[w_set];

    assign bus.cmd_ready     = (r_state == IDLE);
    assign bus.rsp_valid     = r_rsp_valid;
    assign bus.rsp_rdata     = r_rsp_rdata;
    assign bus.rsp_hit       = r_rsp_hit;
    assign bus.mem_req_valid = r_req_valid;
    assign bus.mem_req_we    = r_req_we;
    assign bus.mem_req_addr  = r_req_addr;
    assign bus.mem_req_wdata = r_req_wdata;
    assign bus.hit_cnt       = r_hit_cnt;
    assign bus.miss_cnt      = r_miss_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_op        <= OP_NOP;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_hit       <= 1'b0;
            r_fcnt      <= '0;
            for (int s = 0; s < NSETS; s++) r_valid[s] <= '0;
            r_lru       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_hit   <= 1'b0;
            r_rsp_rdata <= '0;
            r_req_valid <= 1'b0;
            r_req_we    <= 1'b0;
            r_req_addr  <= '0;
            r_req_wdata <= '0;
            r_hit_cnt   <= '0;
            r_miss_cnt  <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                IDLE: if (bus.cmd_valid) begin
                    r_op    <= bus.cmd_op;
                    r_addr  <= bus.cmd_addr;
                    r_wdata <= bus.cmd_wdata;
                    r_fcnt  <= '0;
                    r_state <= bus.cmd_op == OP_FL ? FLUSH : bus.cmd_op == OP_NOP ? IDLE : LOOKUP;
                end
                LOOKUP: begin
                    r_hit <= w_hit;
                    if (w_hit) begin
                        r_lru[w_set] <= ~w_way;
                        r_hit_cnt    <= r_hit_cnt + CNT_W'(~&r_hit_cnt);
                    end else begin
                        r_miss_cnt <= r_miss_cnt + CNT_W'(~&r_miss_cnt);
                    end
                    if (w_hit && r_op == OP_RD) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= r_data[w_way][w_set];
                        r_rsp_hit   <= 1'b1;
                        r_state     <= RESP;
                    end else begin
                        r_req_valid <= 1'b1;
                        r_req_we    <= (r_op == OP_WR);
                        r_req_addr  <= r_addr;
                        r_req_wdata <= r_wdata;
                        r_state     <= MEM_REQ;
                    end
                end
                MEM_REQ: if (bus.mem_req_ready) begin
                    r_req_valid <= 1'b0;
                    if (r_req_we) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= '0;
                        r_rsp_hit   <= r_hit;
                        r_state     <= RESP;
                    end else begin
                        r_state <= MEM_WAIT;
                    end
                end
                MEM_WAIT: if (bus.mem_rsp_valid) begin
                    r_valid[w_set][w_victim] <= 1'b1;
                    r_lru[w_set] <= ~w_victim;
                    r_rsp_valid  <= 1'b1;
                    r_rsp_rdata  <= bus.mem_rsp_rdata;
                    r_rsp_hit    <= 1'b0;
                    r_state      <= RESP;
                end
                // 16 clearing cycles, then one cycle with the counter's top bit set to finish
                FLUSH: if (r_fcnt[SET_BITS]) begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_rdata <= '0;
                    r_rsp_hit   <= 1'b0;
                    r_state     <= RESP;
                end else begin
                    r_valid[r_fcnt[SET_BITS-1:0]] <= '0;
                    r_lru[r_fcnt[SET_BITS-1:0]]   <= 1'b0;
                    r_fcnt <= r_fcnt + 1'b1;
                end
                RESP:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == LOOKUP && w_hit && r_op == OP_WR) r_data[w_way][w_set] <= r_wdata;
        if (r_state == MEM_WAIT && bus.mem_rsp_valid) begin
            r_tag[w_victim][w_set]  <= w_tag;
            r_data[w_victim][w_set] <= bus.mem_rsp_rdata;
        end
    end
endmodule

// File: doc/sa_cache_ctrl.md
Name: sa_cache_ctrl

Overview:
- Controller for the 2-way set-associative cache.
- Accepts command-stream entries (2-bit command, 12-bit word address, 32-bit data) from the stimulus/command source.
- Sequences tag lookup, LRU update, line fill and write-through to backing memory.
- Sits between the command source and a single-port memory with a valid/ready request channel; holds the tag, valid, LRU and data arrays internally.

Parameters:
- ADDR_W, 12, word address width
- DATA_W, 32, data word width
- SET_BITS, 4, log2 of number of sets (16 sets); tag width = ADDR_W-SET_BITS = 8
- CNT_W, 16, width of hit/miss statistics counters

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller can accept a command (high only in IDLE)
- cmd_op  in  2  00 NOP, 01 READ, 10 WRITE, 11 FLUSH
- cmd_addr  in  ADDR_W  word address; set = addr[SET_BITS-1:0], tag = upper bits
- cmd_wdata  in  DATA_W  write data
- rsp_valid  out  1  one-cycle completion pulse (no backpressure)
- rsp_rdata  out  DATA_W  read data (0 for WRITE/FLUSH)
- rsp_hit  out  1  command hit in cache (0 for FLUSH)
- mem_req_valid  out  1  memory request
- mem_req_ready  in  1  memory accepts request
- mem_req_we  out  1  1 = write, 0 = read
- mem_req_addr  out  ADDR_W  memory word address
- mem_req_wdata  out  DATA_W  memory write data
- mem_rsp_valid  in  1  read data returned (any cycle after request handshake)
- mem_rsp_rdata  in  DATA_W  memory read data
- hit_cnt  out  CNT_W  saturating count of READ/WRITE hits
- miss_cnt  out  CNT_W  saturating count of READ/WRITE misses

Behaviour:
- Reset (async, rst_n=0):
  - State→IDLE; all valid bits and LRU bits cleared; hit_cnt/miss_cnt=0.
  - rsp_valid=0, rsp_rdata=0, rsp_hit=0; mem_req_valid=0, mem_req_we=0, addr/wdata=0.
  - Data and tag arrays are not reset.
  - Reset mid-operation abandons the command: no response; an outstanding memory read response is ignored.
- FSM states: IDLE, LOOKUP, MEM_REQ, MEM_WAIT, FLUSH, RESP.
- IDLE:
  - cmd_ready=1; handshake on cmd_valid&cmd_ready registers op/addr/wdata.
  - NOP is consumed and dropped (stay IDLE, no response). FLUSH→FLUSH with set counter=0. READ/WRITE→LOOKUP.
- LOOKUP (one cycle): hit = valid[w] & tag match for way w; at most one way hits.
  - READ hit: latch data, LRU[set]=~w, hit_cnt++ → RESP.
  - READ miss: miss_cnt++ → MEM_REQ (read).
  - WRITE hit: update data way w, LRU[set]=~w, hit_cnt++ → MEM_REQ (write-through).
  - WRITE miss: miss_cnt++, no allocate → MEM_REQ (write).
- MEM_REQ: mem_req_valid held high with stable we/addr/wdata until mem_req_ready. On handshake: write→RESP; read→MEM_WAIT.
- MEM_WAIT: on mem_rsp_valid, fill the victim way and → RESP.
  - Victim is the lowest-numbered invalid way, else the LRU[set] way.
  - Fill sets valid, writes tag and data, sets LRU[set]=~victim, latches data.
- FLUSH: clears valid[*][counter] and LRU[counter] each cycle, counter++; after set 2^SET_BITS-1 (16 cycles) → RESP.
- RESP (one cycle): rsp_valid=1 with rdata/hit, then → IDLE. cmd_ready=0 in every non-IDLE state.
- Latency, accept cycle T: read hit rsp_valid at T+2; write with mem_req_ready=1 at T+3; FLUSH at T+18.
- Counters saturate at 2^CNT_W-1; NOP/FLUSH never count.

Test Plan:
- Reset, READ 0x0A5 with memory returning 0x1234 → mem read addr 0x0A5, rsp hit=0 rdata 0x1234, miss_cnt=1. Repeat READ → rsp at accept+2, hit=1 rdata 0x1234, no mem request, hit_cnt=1.
- LRU eviction (set 5):
  - Fill tags 0x01 and 0x02: READ 0x015, 0x025.
  - READ 0x015 (hit), then READ 0x035 (miss) → way holding 0x025 evicted.
  - READ 0x015 hits; READ 0x025 misses.
- WRITE 0x015 data 0xDEADBEEF after it is cached, mem_req_ready held low 3 cycles → mem_req_valid stable 4 cycles, rsp hit=1. READ 0x015 hits with 0xDEADBEEF. WRITE to uncached 0x7F0 → hit=0; later READ 0x7F0 misses (no allocate).
- FLUSH after caching 0x015 → rsp 18 cycles after accept, hit=0; READ 0x015 then misses; counters unchanged by FLUSH.
- NOP and back-to-back commands: NOP accepted, no rsp_valid; cmd_ready low from accept until the cycle after rsp_valid.
- Reset mid-operation: assert rst_n=0 while in MEM_WAIT → outputs zero immediately. Late mem_rsp_valid after reset ignored. Counters 0; READ of the same address misses.
